sevenseg_scan_ctrl: RTL and testbench

SEVENSEG_SCAN_CTRL -- requirements
Module: sevenseg_scan_ctrl

---
 rtl/sevenseg_pkg.sv | 23 ++
 rtl/sevenseg_decoder.sv | 13 +
 rtl/sevenseg_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_sevenseg_scan_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   scan_st_e        : scan FSM state encoding
//   DEF_NUM_DIGITS   : default number of multiplexed digits
//   DEF_BLANK_CYCLES : default anti-ghosting blank time before each digit
//   SEG_TAB          : hex nibble -> segments g..a (bit 6..0), active-high
package sevenseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_st_e;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_BLANK_CYCLES = 4;

  // Entry 0 sits in the least significant slot, so the list reads F..0.
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sevenseg_decoder.sv
// Combinational hex-to-seven-segment decoder.
//   nib : 4-bit hex value
//   seg : segments g..a in [6:0], active-high
module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_TAB[nib];

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment display scanner with a double-buffered load path.
// Each digit is preceded by BLANK_CYCLES of all-off time, then shown for
// max(period_i,1) cycles. New data is captured into a pending buffer and only
// moved to the displayed buffer at a frame boundary or while idle.
//   wb_clk_i / wb_rst_i : clock, async active-high reset
//   en_i                : scan enable
//   digits_i / dp_i     : nibbles (digit 0 in [3:0]) and decimal points
//   load_i              : capture strobe for digits_i/dp_i
//   period_i            : on-time per digit (0 behaves as 1)
//   load_ack_o          : pulse when captured data becomes the displayed data
//   seg_o / dp_o / an_o : segment, decimal point and one-hot anode drives
//   frame_o             : pulse after each frame boundary
//   oeb_o               : pad output-enable-bar, follows ~en_i
module sevenseg_scan_ctrl
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter int PERIOD_W     = 16
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic                      en_i,
  input  logic [4*NUM_DIGITS-1:0]   digits_i,
  input  logic [NUM_DIGITS-1:0]     dp_i,
  input  logic                      load_i,
  input  logic [PERIOD_W-1:0]       period_i,
  output logic                      load_ack_o,
  output logic [6:0]                seg_o,
  output logic                      dp_o,
  output logic [NUM_DIGITS-1:0]     an_o,
  output logic                      frame_o,
  output logic [NUM_DIGITS+7:0]     oeb_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = $clog2(BLANK_CYCLES + 1);
  localparam int CNT_W = (PERIOD_W > BLK_W) ? PERIOD_W : BLK_W;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] dig;
    logic [NUM_DIGITS-1:0]      dp;
  } disp_t;

  disp_t               active, pending;
  logic                pend;
  scan_st_e            st, st_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [PERIOD_W-1:0] per_lat, per_nxt;
  logic                boundary, xfer, show;
  logic [6:0]          seg_dec;
  // [0] = transfer happened last edge, [1] = ack output
  logic [1:0]          ack_pipe;

  always_comb begin
    st_nxt   = st;
    idx_nxt  = idx;
    cnt_nxt  = cnt;
    per_nxt  = per_lat;
    boundary = 1'b0;
    case (st)
      ST_IDLE: begin
        idx_nxt = '0;
        cnt_nxt = '0;
        st_nxt  = ST_BLANK;
      end
      ST_BLANK: begin
        if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
          st_nxt  = ST_SHOW;
          cnt_nxt = '0;
          // On-time is frozen for the whole digit.
          per_nxt = (period_i == '0) ? PERIOD_W'(1) : period_i;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_SHOW: begin
        if (cnt == CNT_W'(per_lat) - CNT_W'(1)) begin
          st_nxt  = ST_BLANK;
          cnt_nxt = '0;
          if (idx == IDX_W'(NUM_DIGITS - 1)) begin
            idx_nxt  = '0;
            boundary = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: st_nxt = ST_IDLE;
    endcase
    // Disable overrides everything, including a boundary in the same cycle.
    if (!en_i) begin
      st_nxt   = ST_IDLE;
      idx_nxt  = '0;
      cnt_nxt  = '0;
      boundary = 1'b0;
    end
  end

  assign xfer = pend && (boundary || (st == ST_IDLE));
  assign show = en_i && (st == ST_SHOW);

  sevenseg_decoder u_dec (
    .nib (active.dig[idx]),
    .seg (seg_dec)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      st      <= ST_IDLE;
      idx     <= '0;
      cnt     <= '0;
      per_lat <= '0;
    end else begin
      st      <= st_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      per_lat <= per_nxt;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      active   <= '0;
      pending  <= '0;
      pend     <= 1'b0;
      ack_pipe <= '0;
    end else begin
      if (xfer)   active  <= pending;
      if (load_i) pending <= '{dig: digits_i, dp: dp_i};
      // A load in the transfer cycle keeps the flag set for the new data.
      pend     <= load_i | (pend & ~xfer);
      ack_pipe <= {ack_pipe[0], xfer};
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      seg_o   <= '0;
      dp_o    <= 1'b0;
      an_o    <= '0;
      frame_o <= 1'b0;
      oeb_o   <= '1;
    end else begin
      seg_o   <= show ? seg_dec : 7'h00;
      dp_o    <= show & active.dp[idx];
      an_o    <= show ? (NUM_DIGITS'(1) << idx) : '0;
      frame_o <= boundary;
      oeb_o   <= {(NUM_DIGITS + 8){~en_i}};
    end
  end

  assign load_ack_o = ack_pipe[1];

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl. The driver computes each cycle's
// expected registered outputs from a frame-position model and queues them;
// the monitor pops one entry per clock and compares.
module tb_sevenseg_scan_ctrl;

  localparam int N  = 4;
  localparam int B  = 4;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [4*N-1:0] digits = '0;
  logic [N-1:0]  dpi = '0;
  logic          load = 1'b0;
  logic [PW-1:0] period = '0;
  logic          load_ack;
  logic [6:0]    seg;
  logic          dpo;
  logic [N-1:0]  an;
  logic          frame;
  logic [N+7:0]  oeb;

  sevenseg_scan_ctrl #(.NUM_DIGITS(N), .BLANK_CYCLES(B), .PERIOD_W(PW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .digits_i(digits), .dp_i(dpi),
    .load_i(load), .period_i(period), .load_ack_o(load_ack), .seg_o(seg),
    .dp_o(dpo), .an_o(an), .frame_o(frame), .oeb_o(oeb)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] an;
    logic         frame;
    logic         ack;
    logic [N+7:0] oeb;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   running = 0;

  int seg_tab [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

  // Reference model: display position within the frame, plus the two buffers.
  bit          m_on;
  int          m_pos;
  logic [15:0] m_act, m_pnd;
  logic [3:0]  m_act_dp, m_pnd_dp;
  bit          m_pend, m_last_xfer;

  function automatic int slot_len(input logic [PW-1:0] p);
    return B + ((p == 0) ? 1 : int'(p));
  endfunction

  task automatic model_reset();
    m_on = 0; m_pos = 0; m_act = '0; m_pnd = '0; m_act_dp = '0; m_pnd_dp = '0;
    m_pend = 0; m_last_xfer = 0;
  endtask

  task automatic check(input string name, input exp_t got, input exp_t want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t got seg=%h dp=%b an=%b fr=%b ack=%b oeb=%h want seg=%h dp=%b an=%b fr=%b ack=%b oeb=%h",
                  name, $time, got.seg, got.dp, got.an, got.frame, got.ack, got.oeb,
                  want.seg, want.dp, want.an, want.frame, want.ack, want.oeb);
  endtask

  function automatic exp_t dut_out();
    return '{seg: seg, dp: dpo, an: an, frame: frame, ack: load_ack, oeb: oeb};
  endfunction

  // One clock of stimulus: drive inputs, queue the response after the next edge.
  task automatic step(input bit e, input bit ld, input logic [15:0] d,
                      input logic [3:0] dp, input logic [PW-1:0] p);
    exp_t x;
    int   sl, fl, dg;
    bit   bnd, xf;
    @(negedge clk);
    rst = 0; en = e; load = ld; digits = d; dpi = dp; period = p;
    sl = slot_len(p);
    fl = N * sl;
    x  = '0;
    x.oeb = e ? '0 : '1;
    x.ack = m_last_xfer;
    if (e && m_on) begin
      dg = m_pos / sl;
      if ((m_pos % sl) >= B) begin
        x.an  = N'(1) << dg;
        x.seg = 7'(seg_tab[m_act[4*dg +: 4]]);
        x.dp  = m_act_dp[dg];
      end
      x.frame = (m_pos == fl - 1);
    end
    sb.push_back(x);
    bnd = e && m_on && (m_pos == fl - 1);
    xf  = m_pend && (bnd || !m_on);
    m_last_xfer = xf;
    if (xf) begin m_act = m_pnd; m_act_dp = m_pnd_dp; end
    if (ld) begin m_pnd = d; m_pnd_dp = dp; m_pend = 1; end
    else if (xf) m_pend = 0;
    if (!e) begin m_on = 0; m_pos = 0; end
    else if (!m_on) begin m_on = 1; m_pos = 0; end
    else m_pos = (m_pos + 1) % fl;
  endtask

  // Keep scanning until the model reaches a given frame position.
  task automatic run_to(input int tgt, input logic [PW-1:0] p);
    int k;
    for (k = 0; k < 500; k++) begin
      if (m_on && m_pos == tgt) break;
      step(1, 0, m_pnd, m_pnd_dp, p);
    end
    n_chk++;
    if (k < 500) n_pass++;
    else $display("FAIL run_to pos=%0d never reached (at %0d, want %0d)", tgt, m_pos, tgt);
  endtask

  task automatic run(input int cyc, input logic [PW-1:0] p);
    for (int i = 0; i < cyc; i++) step(1, 0, m_pnd, m_pnd_dp, p);
  endtask

  task automatic do_reset(input string name);
    exp_t rz;
    rz = '0; rz.oeb = '1;
    @(negedge clk);
    rst = 1;
    #1 check(name, dut_out(), rz);
    model_reset();
  endtask

  initial begin : monitor
    exp_t w;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (running || sb.size() != 0)) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow got 0 entries want 1");
        end else begin
          w = sb.pop_front();
          check("cycle", dut_out(), w);
        end
      end
    end
  end

  initial begin : driver
    exp_t rz;
    model_reset();
    rz = '0; rz.oeb = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", dut_out(), rz);
    running = 1;
    // Load 0x1234 while idle, then scan with period 3 (28-cycle frames).
    step(0, 1, 16'h1234, 4'b0101, 3);
    step(0, 0, 16'h1234, 4'b0101, 3);
    run(70, 3);
    // Display 0x0000, then load 0xFFFF mid-frame.
    step(0, 1, 16'h0000, 4'b0000, 3);
    step(0, 0, 16'h0000, 4'b0000, 3);
    run(10, 3);
    step(1, 1, 16'hFFFF, 4'b1111, 3);
    run(70, 3);
    // Two loads within one frame: only the second shows.
    run(5, 3);
    step(1, 1, 16'hAAAA, 4'b1010, 3);
    run(6, 3);
    step(1, 1, 16'h8888, 4'b0110, 3);
    run(70, 3);
    // Load in the exact boundary cycle with older data already pending.
    step(1, 1, 16'h5555, 4'b0001, 3);
    run_to(N * (B + 3) - 1, 3);
    step(1, 1, 16'h6666, 4'b1000, 3);
    run(70, 3);
    // Drop enable while showing digit 2, then re-enable.
    run_to(2 * (B + 3) + B, 3);
    step(0, 0, m_pnd, m_pnd_dp, 3);
    step(0, 0, m_pnd, m_pnd_dp, 3);
    run(40, 3);
    // Period 0 behaves as 1; reset while a digit is shown.
    step(0, 1, 16'h9C3E, 4'b0011, 0);
    run(30, 0);
    run_to(B, 0);
    do_reset("reset_mid_show");
    step(0, 0, 16'h0, 4'h0, 0);
    run(20, 0);
    // Reset with a load pending: no ack and the data is discarded.
    step(1, 1, 16'h7777, 4'b1111, 0);
    do_reset("reset_mid_load");
    run(40, 0);
    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      logic e;
      logic [PW-1:0] p;
      if ($urandom_range(0, 399) == 0) do_reset("reset_rand");
      e = ($urandom_range(0, 99) < 96);
      p = e ? period : PW'($urandom_range(0, 4));
      step(e, $urandom_range(0, 99) < 4, 16'($urandom), 4'($urandom), p);
    end
    running = 0;
    @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
